// File: rtl/dram_req_ctrl.sv
// Single-outstanding request controller for the 4x72-bit dram array.
// Define DRAM_CTRL_PARITY_EN to store/check even parity per byte in bits [71:64].
module dram_req_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [1:0]       req_addr,
   input  logic [63:0]      req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_rdata,
   output logic [7:0]       rsp_perr,
   output logic             mem_write_en,
   output logic             mem_read_en,
   output logic [1:0]       mem_address,
   output logic [71:0]      mem_data_in,
   input  logic [71:0]      mem_data_out,
   output logic [CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_RDW  = 3'd3,
      S_RSP  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             req_ready_q, req_ready_d;
   logic             mem_write_en_q, mem_write_en_d;
   logic             mem_read_en_q, mem_read_en_d;
   logic [1:0]       mem_address_q, mem_address_d;
   logic [71:0]      mem_data_in_q, mem_data_in_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [63:0]      rsp_rdata_q, rsp_rdata_d;
   logic [7:0]       rsp_perr_q, rsp_perr_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [7:0]       wr_chk_s;
   logic [7:0]       rd_perr_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

`ifdef DRAM_CTRL_PARITY_EN
   function automatic logic [7:0] byte_parity(input logic [63:0] d);
      logic [7:0] p;
      for (int i = 0; i < 8; i++) begin
         p[i] = ^d[8*i +: 8];
      end
      return p;
   endfunction

   function automatic logic [7:0] parity_check(input logic [71:0] w);
      logic [7:0] e;
      for (int i = 0; i < 8; i++) begin
         e[i] = ^{w[64+i], w[8*i +: 8]};
      end
      return e;
   endfunction

   assign wr_chk_s  = byte_parity(req_wdata);
   assign rd_perr_s = parity_check(mem_data_out);
`else
   logic unused_chk_s;
   assign unused_chk_s = ^mem_data_out[71:64];
   assign wr_chk_s     = 8'h00;
   assign rd_perr_s    = 8'h00;
`endif

   // Next-state and next-output decode; outputs are registered one state ahead.
   always_comb begin
      state_d        = state_q;
      req_ready_d    = req_ready_q;
      mem_write_en_d = mem_write_en_q;
      mem_read_en_d  = mem_read_en_q;
      mem_address_d  = mem_address_q;
      mem_data_in_d  = mem_data_in_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_rdata_d    = rsp_rdata_q;
      rsp_perr_d     = rsp_perr_q;
      wr_cnt_d       = wr_cnt_q;
      rd_cnt_d       = rd_cnt_q;
      err_cnt_d      = err_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               mem_address_d = req_addr;
               mem_data_in_d = {wr_chk_s, req_wdata};
               req_ready_d   = 1'b0;
               if (req_write) begin
                  state_d        = S_WR;
                  mem_write_en_d = 1'b1;
               end else begin
                  state_d       = S_RD;
                  mem_read_en_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR: begin
            mem_write_en_d = 1'b0;
            req_ready_d    = 1'b1;
            wr_cnt_d       = sat_inc(wr_cnt_q);
            state_d        = S_IDLE;
         end
         S_RD: begin
            mem_read_en_d = 1'b0;
            state_d       = S_RDW;
         end
         S_RDW: begin
            rsp_rdata_d = mem_data_out[63:0];
            rsp_perr_d  = rd_perr_s;
            rd_cnt_d    = sat_inc(rd_cnt_q);
            if (rd_perr_s != 8'h00) begin
               err_cnt_d = sat_inc(err_cnt_q);
            end else begin
               err_cnt_d = err_cnt_q;
            end
            rsp_valid_d = 1'b1;
            state_d     = S_RSP;
         end
         S_RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               state_d = S_RSP;
            end
         end
         default: begin
            state_d        = S_IDLE;
            req_ready_d    = 1'b1;
            mem_write_en_d = 1'b0;
            mem_read_en_d  = 1'b0;
            rsp_valid_d    = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         req_ready_q    <= 1'b1;
         mem_write_en_q <= 1'b0;
         mem_read_en_q  <= 1'b0;
         mem_address_q  <= 2'd0;
         mem_data_in_q  <= 72'd0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= 64'd0;
         rsp_perr_q     <= 8'd0;
         wr_cnt_q       <= {CNT_W{1'b0}};
         rd_cnt_q       <= {CNT_W{1'b0}};
         err_cnt_q      <= {CNT_W{1'b0}};
      end else begin
         state_q        <= state_d;
         req_ready_q    <= req_ready_d;
         mem_write_en_q <= mem_write_en_d;
         mem_read_en_q  <= mem_read_en_d;
         mem_address_q  <= mem_address_d;
         mem_data_in_q  <= mem_data_in_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_perr_q     <= rsp_perr_d;
         wr_cnt_q       <= wr_cnt_d;
         rd_cnt_q       <= rd_cnt_d;
         err_cnt_q      <= err_cnt_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign mem_write_en = mem_write_en_q;
   assign mem_read_en  = mem_read_en_q;
   assign mem_address  = mem_address_q;
   assign mem_data_in  = mem_data_in_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_perr     = rsp_perr_q;
   assign wr_cnt       = wr_cnt_q;
   assign rd_cnt       = rd_cnt_q;
   assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_dram_req_ctrl.sv
// Self-checking bench for dram_req_ctrl: transaction-level model, array model, per-cycle compare.
module tb_dram_req_ctrl;

`ifdef DRAM_CTRL_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
   logic [1:0]  req_addr = 2'd0;
   logic [63:0] req_wdata = 64'd0;
   logic [71:0] mem_data_out = 72'd0;

   logic        req_ready, rsp_valid, mem_write_en, mem_read_en;
   logic [63:0] rsp_rdata;
   logic [7:0]  rsp_perr;
   logic [1:0]  mem_address;
   logic [71:0] mem_data_in;
   logic [15:0] wr_cnt, rd_cnt, err_cnt;

   logic        w2_req_ready, w2_rsp_valid, w2_mem_write_en, w2_mem_read_en;
   logic [63:0] w2_rsp_rdata;
   logic [7:0]  w2_rsp_perr;
   logic [1:0]  w2_mem_address;
   logic [71:0] w2_mem_data_in;
   logic [1:0]  w2_wr_cnt, w2_rd_cnt, w2_err_cnt;

   dram_req_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_perr(rsp_perr), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt));

   dram_req_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w2_req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(w2_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(w2_rsp_rdata),
      .rsp_perr(w2_rsp_perr), .mem_write_en(w2_mem_write_en), .mem_read_en(w2_mem_read_en),
      .mem_address(w2_mem_address), .mem_data_in(w2_mem_data_in), .mem_data_out(mem_data_out),
      .wr_cnt(w2_wr_cnt), .rd_cnt(w2_rd_cnt), .err_cnt(w2_err_cnt));

   always #5 clk = ~clk;

   // Array model: registered read, optional single-bit corruption of bit 9.
   logic [71:0] arr [4];
   bit          flip = 1'b0;
   always @(posedge clk) begin
      if (mem_write_en) arr[mem_address] <= mem_data_in;
      if (mem_read_en)  mem_data_out <= arr[mem_address] ^ (flip ? 72'h200 : 72'h0);
   end

   // Rising edges of the CNT_W=2 instance's write enable.
   int we_pulses = 0;
   logic we_prev = 1'b0;
   always @(posedge clk) begin
      if (w2_mem_write_en && !we_prev) we_pulses <= we_pulses + 1;
      we_prev <= w2_mem_write_en;
   end

   // Reference model state.
   logic [63:0] shadow [4];
   bit          written [4];
   bit          exp_ready = 1'b1, exp_we = 1'b0, exp_re = 1'b0, exp_rv = 1'b0;
   logic [1:0]  exp_addr = 2'd0;
   logic [71:0] exp_din = 72'd0;
   logic [63:0] exp_rdata = 64'd0;
   logic [7:0]  exp_perr = 8'd0;
   int          exp_wr = 0, exp_rd = 0, exp_err = 0, exp_wr2 = 0, exp_rd2 = 0, exp_err2 = 0;
   int          ntests = 0, nfail = 0;

   function automatic logic [7:0] even_par(input logic [63:0] d);
      logic [7:0] p;
      for (int i = 0; i < 8; i++) p[i] = ^d[8*i +: 8];
      return PAR ? p : 8'h00;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v < mx) ? v + 1 : v;
   endfunction

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("req_ready", req_ready, exp_ready);
      chk("mem_write_en", mem_write_en, exp_we);
      chk("mem_read_en", mem_read_en, exp_re);
      chk("mem_address", mem_address, exp_addr);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_perr", rsp_perr, exp_perr);
      chk("wr_cnt", wr_cnt, exp_wr);
      chk("rd_cnt", rd_cnt, exp_rd);
      chk("err_cnt", err_cnt, exp_err);
      chk("w2_mem_write_en", w2_mem_write_en, exp_we);
      chk("w2_wr_cnt", w2_wr_cnt, exp_wr2);
      chk("w2_rd_cnt", w2_rd_cnt, exp_rd2);
      chk("w2_err_cnt", w2_err_cnt, exp_err2);
      if (exp_we || rst) chk("mem_data_in", mem_data_in, exp_din);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic junk_req();
      req_valid = 1'($urandom);
      req_write = 1'($urandom);
      req_addr  = 2'($urandom);
      req_wdata = {$urandom, $urandom};
   endtask

   task automatic model_reset();
      exp_ready = 1'b1; exp_we = 1'b0; exp_re = 1'b0; exp_rv = 1'b0;
      exp_addr = 2'd0; exp_din = 72'd0; exp_rdata = 64'd0; exp_perr = 8'd0;
      exp_wr = 0; exp_rd = 0; exp_err = 0; exp_wr2 = 0; exp_rd2 = 0; exp_err2 = 0;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [63:0] d, output logic [7:0] got_chk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
      step();
      exp_ready = 1'b0; exp_we = 1'b1; exp_addr = a; exp_din = {even_par(d), d};
      got_chk = mem_data_in[71:64];
      junk_req(); rsp_ready = 1'($urandom);
      step();
      shadow[a] = d; written[a] = 1'b1;
      exp_we = 1'b0; exp_ready = 1'b1;
      exp_wr = sat(exp_wr, 65535); exp_wr2 = sat(exp_wr2, 3);
      req_valid = 1'b0;
   endtask

   task automatic do_read(input logic [1:0] a, input int hold, input bit f,
                          output logic [63:0] got_rdata, output logic [7:0] got_perr);
      req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = {$urandom, $urandom};
      step();
      exp_ready = 1'b0; exp_re = 1'b1; exp_addr = a; flip = f;
      junk_req(); rsp_ready = 1'($urandom);
      step();
      exp_re = 1'b0; flip = 1'b0;
      junk_req(); rsp_ready = 1'($urandom);
      step();
      exp_rv = 1'b1;
      exp_rdata = shadow[a] ^ (f ? 64'h200 : 64'h0);
      exp_perr = (f && PAR) ? 8'h02 : 8'h00;
      exp_rd = sat(exp_rd, 65535); exp_rd2 = sat(exp_rd2, 3);
      if (exp_perr != 8'h00) begin
         exp_err = sat(exp_err, 65535); exp_err2 = sat(exp_err2, 3);
      end
      got_rdata = rsp_rdata; got_perr = rsp_perr;
      junk_req(); rsp_ready = 1'b0;
      repeat (hold) step();
      rsp_ready = 1'b1;
      step();
      exp_rv = 1'b0; exp_ready = 1'b1;
      rsp_ready = 1'b0; req_valid = 1'b0;
   endtask

   logic [7:0]  gc, gp;
   logic [63:0] gd;
   int          w0;

   initial begin
      #2 rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Basic write then read of address 2.
      do_write(2'd2, 64'h0123456789ABCDEF, gc);
      do_read(2'd2, 0, 1'b0, gd, gp);
      chk("tp_rdata", gd, 64'h0123456789ABCDEF);
      chk("tp_perr", gp, 8'h00);
      chk("tp_wr_cnt", wr_cnt, 1);
      chk("tp_rd_cnt", rd_cnt, 1);

      // Response back-pressure for 5 cycles.
      do_read(2'd2, 5, 1'b0, gd, gp);
      chk("bp_req_ready", req_ready, 1'b1);

      // Check-bit generation.
      do_write(2'd1, 64'h00000000000000FF, gc);
      chk("par_ff", gc, 8'h00);
      do_write(2'd3, 64'h0000000000000001, gc);
      chk("par_01", gc, PAR ? 8'h01 : 8'h00);

      // Corrupted read-back of bit 9.
      do_read(2'd1, 1, 1'b1, gd, gp);
      chk("flip_perr", gp, PAR ? 8'h02 : 8'h00);
      chk("flip_rdata", gd, 64'h00000000000002FF);
      chk("flip_err_cnt", err_cnt, PAR ? 1 : 0);

      // Reset while the read is waiting for array data.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2;
      step();
      exp_ready = 1'b0; exp_re = 1'b1; exp_addr = 2'd2; req_valid = 1'b0;
      step();
      exp_re = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_wr_cnt", wr_cnt, 0);
      repeat (2) step();
      rst = 1'b0;
      repeat (3) step();
      chk("rst_req_ready", req_ready, 1'b1);

      // Counter saturation on the CNT_W=2 instance.
      w0 = we_pulses;
      for (int i = 0; i < 5; i++) do_write(2'(i), {$urandom, $urandom}, gc);
      chk("sat_w2_wr_cnt", w2_wr_cnt, 2'd3);
      chk("sat_wr_cnt", wr_cnt, 5);
      chk("sat_we_pulses", we_pulses - w0, 5);

      // Randomized traffic.
      for (int n = 0; n < 200; n++) begin
         repeat ($urandom_range(0, 2)) begin
            junk_req(); req_valid = 1'b0; rsp_ready = 1'($urandom);
            step();
         end
         if ($urandom_range(0, 1) == 0) begin
            do_write(2'($urandom), {$urandom, $urandom}, gc);
         end else begin
            logic [1:0] a;
            a = 2'($urandom);
            if (written[a]) do_read(a, $urandom_range(0, 3), $urandom_range(0, 3) == 0, gd, gp);
            else do_write(a, {$urandom, $urandom}, gc);
         end
      end
      step();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/dram_req_ctrl.md
# dram_req_ctrl

Request controller upstream of the 4×72-bit `dram` array. It accepts single-word read/write requests over a valid/ready handshake and sequences the array's `write_en`, `read_en`, `address` and `data_in` ports. It captures the array's registered `data_out` and returns read data over a second valid/ready handshake. Optional per-byte parity uses the array's 8 spare bits (72 = 64 data + 8 check); access and error counters are kept for software visibility.

## Interface
- `CNT_W`, default 16: width of `wr_cnt`, `rd_cnt`, `err_cnt`.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 2: word address.
- `req_wdata` in 64: write data.
- `rsp_valid` out 1: read response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 64: read data.
- `rsp_perr` out 8: per-byte parity error flags; bit i covers byte i.
- `mem_write_en` out 1: drives the array's `write_en`.
- `mem_read_en` out 1: drives the array's `read_en`.
- `mem_address` out 2: drives the array's `address`.
- `mem_data_in` out 72: drives the array's `data_in`.
- `mem_data_out` in 72: from the array's `data_out`, valid the cycle after a `read_en` edge.
- `wr_cnt` out CNT_W: completed writes, saturating.
- `rd_cnt` out CNT_W: captured reads, saturating.
- `err_cnt` out CNT_W: reads with any `rsp_perr` bit set, saturating.

## Operation
- **Moore FSM** with states IDLE, WR, RD, RDW, RSP. All `mem_*` and `req_ready` outputs decode from state and latched registers only; no combinational path from request inputs to outputs.
- **IDLE**
  - `req_ready`=1, `mem_write_en`=`mem_read_en`=0.
  - On `req_valid`&&`req_ready`: latch addr, write flag and wdata.
  - Go to WR if write, else RD.
- **WR**
  - `mem_write_en`=1, `mem_data_in`={check bits, latched wdata}.
  - Increment `wr_cnt`; next state IDLE.
- **RD**
  - `mem_read_en`=1; next state RDW.
- **RDW**
  - Both enables 0; `mem_data_out` is valid in this cycle.
  - At the edge: capture `rsp_rdata`=`mem_data_out[63:0]`, compute `rsp_perr`, increment `rd_cnt`, increment `err_cnt` if `rsp_perr`≠0.
  - Next state RSP.
- **RSP**
  - `rsp_valid`=1; `rsp_rdata`/`rsp_perr` held stable.
  - On `rsp_valid`&&`rsp_ready`: clear `rsp_valid`, go to IDLE.
- `mem_address` always equals the latched address; it is held in every state.
- Only one request is outstanding; `req_ready`=0 in every state except IDLE.
- `req_*` inputs are ignored outside the IDLE handshake.
- Counters saturate at 2^CNT_W−1 and never wrap.
- A read of a never-written word returns whatever the array holds; this is undefined and is not the controller's concern.

## Timing
- **Reset values:**
  - FSM state: IDLE.
  - `req_ready`: 1.
  - 0: `rsp_valid`, `rsp_rdata`, `rsp_perr`, `mem_write_en`, `mem_read_en`, `mem_address`, `mem_data_in`, all counters.
- **Write:** accepted at edge E0; array written at E1; `req_ready`=1 again after E1. Throughput is 1 write per 2 cycles.
- **Read:** accepted at E0; `read_en` sampled at E1; response captured at E2; `rsp_valid`=1 after E2. Minimum accept-to-accept interval is 4 cycles.
- A response handshake at edge E returns the FSM to IDLE after E. There is no same-cycle accept of the next request.
- Reset asserted mid-operation aborts the operation immediately:
  - No response is produced.
  - Counters clear.
  - An in-flight array write may or may not have completed.

## Configuration
- `DRAM_CTRL_PARITY_EN` defined:
  - On write: `mem_data_in[64+i]` = ^`wdata[8i+7:8i]` (even parity per byte).
  - On read: `rsp_perr[i]` = ^{`mem_data_out[64+i]`, `mem_data_out[8i+7:8i]`}.
- Not defined:
  - `mem_data_in[71:64]`=0.
  - `rsp_perr` is constantly 0, so `err_cnt` stays 0.
  - Parity logic is absent.

## Test plan
- Write addr 2 = 0x0123456789ABCDEF, then read addr 2 → `rsp_rdata`=0x0123456789ABCDEF, `rsp_perr`=0x00, `rsp_valid` rises 2 edges after read accept, `wr_cnt`=1, `rd_cnt`=1.
- Read with `rsp_ready` held 0 for 5 cycles → `rsp_valid`/`rsp_rdata` stable and `req_ready`=0 throughout; after the handshake, `req_ready`=1 the next cycle.
- Parity on, write wdata 0x00000000000000FF then 0x0000000000000001 → `mem_data_in[71:64]`=0x00 then 0x01; parity off → 0x00 both times.
- Parity on, bench array model flips `mem_data_out[9]` on a read → `rsp_perr`=0x02, `err_cnt`=1.
- Assert `rst` during RDW → no `rsp_valid`, all outputs at reset values, `req_ready`=1 after release.
- CNT_W=2, 5 back-to-back writes → `wr_cnt`=3 (saturated) and `mem_write_en` pulses 5 times, each one cycle wide.
